cpu_trace_streamer: RTL and testbench
=====================================

Name: cpu_trace_streamer

Overview:
Hardware counterpart of the simulation trace dump. On each instruction-retire pulse it snapshots pc and instruction, then walks the register file through a debug read port. It emits 34 tagged 32-bit words (pc, instr, reg0..reg31) over a valid/ready stream to a UART or host bridge. It sits beside the CPU inside sccomp_dataflow.

Parameters:
DATA_W, 32, width of pc, instruction, register and output words
NREG, 32, registers dumped per record (register index width fixed at 5)
CNT_W, 16, width of the dropped-record counter

Ports:
clk_in  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
commit  input  1  one-cycle pulse: the instruction in pc_in/inst_in retires this cycle
pc_in  input  32  pc of the retiring instruction
inst_in  input  32  retiring instruction word
dbg_raddr  output  5  register-file debug read address
dbg_rdata  input  32  register-file debug read data (combinational from dbg_raddr, same cycle)
out_valid  output  1  out_data/out_tag/out_last are valid
out_ready  input  1  sink accepts the word this cycle
out_data  output  32  record word
out_tag  output  6  0 = pc, 1 = instr, 2..33 = reg[tag-2]
out_last  output  1  high with tag 33
busy  output  1  record in progress; the top level uses it to stall the CPU clock-enable
dropped_cnt  output  16  commits ignored while busy, saturating

Behaviour:
- Reset values: all outputs are 0, state is IDLE, and latched pc/inst are 0. Reset mid-record aborts immediately; no partial record is resumed.
- States:
  - IDLE: if commit, latch pc_in and inst_in, load out_data=pc_in, out_tag=0, out_valid=1, and go to SEND.
  - SEND: word index k runs 0..33. A handshake is out_valid & out_ready.
    - On handshake with k<33: load word k+1 into the output registers.
      - k+1=1: the latched inst.
      - k+1>=2: dbg_rdata, with dbg_raddr = k-1 during that cycle.
    - On handshake with k=33: the record ends.
- Output registers hold stable while out_valid & ~out_ready; no word is lost or repeated.
- dbg_raddr: combinational. It equals the index of the register being loaded at the next edge. It is 0 when no register load is pending.
- out_last = (out_tag==33) & out_valid.
- busy = (state==SEND). The register snapshot is consistent only if the CPU is stalled while busy; the block does not enforce this.
- Latency: commit at cycle N → tag 0 valid in N+1. With out_ready held 1, tags 0..33 appear in N+1..N+34 and busy is high N+1..N+34.
- Back-to-back: a commit in the cycle of the tag-33 handshake is accepted. The new pc is loaded as tag 0 at the next edge, with out_valid staying high and busy staying high.
- Dropped commits:
  - A commit while busy that is not in the tag-33 handshake cycle is ignored.
  - dropped_cnt increments by 1 and saturates at 0xFFFF.
  - Latched pc/inst are unaffected.
- The IDLE commit and the output load are a single edge; there are no bubbles between words while out_ready=1.

Test Plan:
1. Reset then single commit: pc_in=0x00400000, inst_in=0x3C011001, dbg_rdata=0xA0000000|addr, out_ready=1.
   → 34 consecutive words: 0x00400000 (tag 0), 0x3C011001 (tag 1), then 0xA0000000..0xA000001F (tags 2..33). out_last only on tag 33; busy falls the cycle after.
2. Backpressure: out_ready toggling 1,0,0,1,... through the record.
   → out_data/out_tag are stable during every ready-low cycle. The sequence is identical to scenario 1, with no duplicates or gaps.
3. Back-to-back records: second commit (pc 0x00400004) asserted in the tag-33 handshake cycle.
   → tag 0=0x00400004 in the very next cycle, out_valid never drops, dropped_cnt=0.
4. Dropped commits: 3 commit pulses during tags 5..20.
   → record content unchanged, dropped_cnt=3.
   Force 70000 drops → dropped_cnt saturates at 0xFFFF.
5. Reset mid-record: assert reset asynchronously at tag 12, between clock edges.
   → out_valid, busy, out_tag and dbg_raddr go to 0 immediately. A subsequent commit restarts at tag 0 with the new pc.
6. Commit in IDLE with out_ready=0 for 10 cycles.
   → out_valid=1 with tag 0 held for all 10 cycles; dbg_raddr is unused until the tag-1 handshake.

Source files
------------

// File: rtl/cpu_trace_streamer.sv
// rtl/cpu_trace_streamer.sv - retire-triggered pc/instr/register-file trace record streamer
// Emits 34 tagged words per record: pc, instr, then reg0..reg31 read through the debug port.
module cpu_trace_streamer #(
  parameter int DATA_W = 32,
  parameter int NREG   = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk_in,
  input  logic              reset,
  input  logic              commit,
  input  logic [DATA_W-1:0] pc_in,
  input  logic [DATA_W-1:0] inst_in,
  output logic [4:0]        dbg_raddr,
  input  logic [DATA_W-1:0] dbg_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [5:0]        out_tag,
  output logic              out_last,
  output logic              busy,
  output logic [CNT_W-1:0]  dropped_cnt
);

  localparam logic [5:0] LAST_TAG = 6'(NREG + 1);

  typedef enum logic {IDLE, SEND} state_t;

  state_t             state_q;
  logic [DATA_W-1:0]  inst_q;
  logic [DATA_W-1:0]  data_q;
  logic [5:0]         tag_q;
  logic               valid_q;
  logic [CNT_W-1:0]   drop_q;

  logic               hs_d;
  logic               last_hs_d;
  logic               accept_d;
  logic               reg_pending_d;
  logic [5:0]         raddr_full_d;

  always_comb begin
    hs_d          = valid_q & out_ready;
    last_hs_d     = hs_d & (tag_q == LAST_TAG);
    // A commit is taken when idle or exactly in the closing handshake of a record.
    accept_d      = commit & ((state_q == IDLE) | last_hs_d);
    reg_pending_d = (state_q == SEND) && (tag_q >= 6'd1) && (tag_q < LAST_TAG);
    raddr_full_d  = tag_q - 6'd1;
    dbg_raddr     = reg_pending_d ? raddr_full_d[4:0] : 5'd0;
  end

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      inst_q  <= '0;
      data_q  <= '0;
      tag_q   <= '0;
      valid_q <= 1'b0;
      drop_q  <= '0;
    end else begin
      if (accept_d) begin
        inst_q  <= inst_in;
        data_q  <= pc_in;
        tag_q   <= 6'd0;
        valid_q <= 1'b1;
        state_q <= SEND;
      end else if (last_hs_d) begin
        tag_q   <= 6'd0;
        valid_q <= 1'b0;
        state_q <= IDLE;
      end else if (hs_d) begin
        tag_q  <= tag_q + 6'd1;
        data_q <= (tag_q == 6'd0) ? inst_q : dbg_rdata;
      end
      if (commit && !accept_d && (drop_q != {CNT_W{1'b1}})) begin
        drop_q <= drop_q + 1'b1;
      end
    end
  end

  assign out_valid   = valid_q;
  assign out_data    = data_q;
  assign out_tag     = tag_q;
  assign out_last    = valid_q & (tag_q == LAST_TAG);
  assign busy        = (state_q == SEND);
  assign dropped_cnt = drop_q;

endmodule

// File: tb/tb_cpu_trace_streamer.sv
// tb/tb_cpu_trace_streamer.sv - self-checking bench for cpu_trace_streamer
module tb_cpu_trace_streamer;

  logic        clk_in = 1'b0;
  logic        reset = 1'b1;
  logic        commit = 1'b0;
  logic [31:0] pc_in = '0;
  logic [31:0] inst_in = '0;
  logic [4:0]  dbg_raddr;
  logic [31:0] dbg_rdata;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_data;
  logic [5:0]  out_tag;
  logic        out_last;
  logic        busy;
  logic [15:0] dropped_cnt;

  logic [31:0] rf [32];

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [31:0] d;
    int          tag;
  } word_t;

  word_t q[$];
  int    dropped_m = 0;

  cpu_trace_streamer dut (
    .clk_in      (clk_in),
    .reset       (reset),
    .commit      (commit),
    .pc_in       (pc_in),
    .inst_in     (inst_in),
    .dbg_raddr   (dbg_raddr),
    .dbg_rdata   (dbg_rdata),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_tag     (out_tag),
    .out_last    (out_last),
    .busy        (busy),
    .dropped_cnt (dropped_cnt)
  );

  assign dbg_rdata = rf[dbg_raddr];

  always #5 clk_in = ~clk_in;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: a record is a queue of 34 words; the head word is on the bus.
  always @(posedge clk_in or posedge reset) begin
    if (reset) begin
      q.delete();
      dropped_m = 0;
    end else begin
      if (q.size() > 0 && out_ready) void'(q.pop_front());
      if (commit) begin
        if (q.size() == 0) begin
          q.push_back('{d: pc_in, tag: 0});
          q.push_back('{d: inst_in, tag: 1});
          for (int i = 0; i < 32; i++) q.push_back('{d: rf[i], tag: i + 2});
        end else if (dropped_m < 65535) begin
          dropped_m++;
        end
      end
    end
  end

  always @(negedge clk_in) begin
    if (!reset) begin
      chk("valid", 32'(out_valid), 32'(q.size() > 0));
      chk("busy", 32'(busy), 32'(q.size() > 0));
      chk("dropped", 32'(dropped_cnt), 32'(dropped_m));
      if (q.size() > 0) begin
        chk("data", out_data, q[0].d);
        chk("tag", 32'(out_tag), 32'(q[0].tag));
        chk("last", 32'(out_last), 32'(q[0].tag == 33));
        if (out_ready && q[0].tag >= 1 && q[0].tag <= 32)
          chk("raddr", 32'(dbg_raddr), 32'(q[0].tag - 1));
      end else begin
        chk("last_idle", 32'(out_last), 32'd0);
        chk("raddr_idle", 32'(dbg_raddr), 32'd0);
      end
    end
  end

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    commit = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: wait bound expired at %0t", name, $time);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy || out_valid) begin
      tick();
      n++;
      if (n > 3000) begin
        timeout("wait_idle");
        break;
      end
    end
  endtask

  task automatic wait_tag(input int t);
    int n = 0;
    while (!(out_valid && out_tag == 6'(t))) begin
      tick();
      n++;
      if (n > 3000) begin
        timeout("wait_tag");
        break;
      end
    end
  endtask

  task automatic start_record(input logic [31:0] pc, input logic [31:0] inst);
    pc_in = pc;
    inst_in = inst;
    commit = 1'b1;
    tick();
    commit = 1'b0;
  endtask

  logic [31:0] cap [34];

  initial begin
    for (int i = 0; i < 32; i++) rf[i] = 32'hA000_0000 | 32'(i);
    do_reset();
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_tag", 32'(out_tag), 32'd0);
    chk("rst_data", out_data, 32'd0);
    chk("rst_dropped", 32'(dropped_cnt), 32'd0);

    // 1: single record with ready held high
    out_ready = 1'b1;
    start_record(32'h0040_0000, 32'h3C01_1001);
    chk("s1_first_valid", 32'(out_valid), 32'd1);
    for (int i = 0; i < 34; i++) begin
      cap[i] = out_data;
      chk("s1_tag_seq", 32'(out_tag), 32'(i));
      chk("s1_last", 32'(out_last), 32'(i == 33));
      tick();
    end
    chk("s1_w0", cap[0], 32'h0040_0000);
    chk("s1_w1", cap[1], 32'h3C01_1001);
    chk("s1_w2", cap[2], 32'hA000_0000);
    chk("s1_w17", cap[17], 32'hA000_000F);
    chk("s1_w33", cap[33], 32'hA000_001F);
    chk("s1_busy_after", 32'(busy), 32'd0);

    // 2: backpressure pattern 1,0,0 repeating
    for (int i = 0; i < 150 && (i < 3 || busy); i++) begin
      out_ready = ((i % 3) == 0);
      if (i == 0) start_record(32'h0040_0000, 32'h3C01_1001);
      else tick();
    end
    out_ready = 1'b1;
    wait_idle();

    // 3: back-to-back records
    do_reset();
    out_ready = 1'b1;
    start_record(32'h0040_0000, 32'h3C01_1001);
    wait_tag(33);
    start_record(32'h0040_0004, 32'h2002_0005);
    chk("s3_valid", 32'(out_valid), 32'd1);
    chk("s3_tag0", 32'(out_tag), 32'd0);
    chk("s3_pc", out_data, 32'h0040_0004);
    wait_idle();
    chk("s3_dropped", 32'(dropped_cnt), 32'd0);

    // 4: dropped commits, then saturation
    do_reset();
    out_ready = 1'b1;
    start_record(32'h0040_0010, 32'h0000_0020);
    for (int k = 5; k <= 15; k += 5) begin
      wait_tag(k);
      start_record(32'hDEAD_0000 + 32'(k), 32'hBEEF_0000);
    end
    wait_idle();
    chk("s4_dropped3", 32'(dropped_cnt), 32'd3);
    out_ready = 1'b0;
    commit = 1'b1;
    for (int i = 0; i < 70000; i++) tick();
    commit = 1'b0;
    chk("s4_saturate", 32'(dropped_cnt), 32'h0000_FFFF);
    out_ready = 1'b1;
    wait_idle();

    // 5: asynchronous reset mid-record
    start_record(32'h0040_0100, 32'h1111_2222);
    wait_tag(12);
    #2;
    reset = 1'b1;
    #1;
    chk("s5_valid", 32'(out_valid), 32'd0);
    chk("s5_busy", 32'(busy), 32'd0);
    chk("s5_tag", 32'(out_tag), 32'd0);
    chk("s5_raddr", 32'(dbg_raddr), 32'd0);
    tick();
    reset = 1'b0;
    start_record(32'h0040_0200, 32'h3333_4444);
    chk("s5_restart_tag", 32'(out_tag), 32'd0);
    chk("s5_restart_pc", out_data, 32'h0040_0200);
    wait_idle();

    // 6: commit while the sink is stalled
    out_ready = 1'b0;
    start_record(32'h0040_0300, 32'h5555_6666);
    for (int i = 0; i < 10; i++) begin
      chk("s6_valid", 32'(out_valid), 32'd1);
      chk("s6_tag", 32'(out_tag), 32'd0);
      chk("s6_data", out_data, 32'h0040_0300);
      tick();
    end
    out_ready = 1'b1;
    wait_idle();

    // Randomized records, random backpressure and stray commits
    for (int r = 0; r < 20; r++) begin
      for (int i = 0; i < 32; i++) rf[i] = $urandom;
      out_ready = ($urandom_range(0, 3) != 0);
      start_record($urandom, $urandom);
      for (int c = 0; c < 60; c++) begin
        out_ready = ($urandom_range(0, 3) != 0);
        commit = ($urandom_range(0, 15) == 0);
        pc_in = $urandom;
        inst_in = $urandom;
        tick();
      end
      commit = 1'b0;
      out_ready = 1'b1;
      wait_idle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
